// File: rtl/spin_pkg.sv
// spin_pkg: shared definitions for the LED-spinner round sequencer.
//   state_e   - round FSM state, encoded as seen on spin_ctrl.state_o
//   SCORE_W   - width of the win tally
//   SCORE_MAX - saturation value of the win tally
package spin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPIN  = 2'd1,
    ST_BRAKE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int unsigned SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/spin_tick_gen.sv
// spin_tick_gen: programmable divider producing a registered one-cycle tick.
// The divider counts 0..period-1. The tick is high in the cycle after the
// divider reaches period-1, and the divider returns to 0 at the same time.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   en     in  count enable; when low, the divider is held at 0 and no tick is made
//   clr    in  synchronous restart of the divider (takes priority over en)
//   period in  interval length in clocks, sampled every cycle
//   tick   out registered one-cycle strobe
module spin_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = '0;
    tick_d = 1'b0;
    if (en && !clr) begin
      if (div_q == period - DIV_W'(1)) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/spin_ctrl.sv
// spin_ctrl: round sequencer for the LED-spinner wheel.
// Generates the wheel tick strobe (constant period while spinning, ramping
// period while braking), raises the stop request once the period saturates,
// waits for the wheel to stop, then latches win/score.
//   clk_i     in  system clock
//   rst_n_i   in  asynchronous active-low reset
//   btn_i     in  player button (synchronised, debounced, level)
//   running_i in  wheel running flag
//   pos_i     in  wheel position
//   tick_o    out one-cycle strobe to the wheel
//   stop_o    out stop request to the wheel
//   state_o   out current FSM state (IDLE 0, SPIN 1, BRAKE 2, HALT 3)
//   win_o     out last round ended on WIN_POS
//   score_o   out saturating count of won rounds
module spin_ctrl
  import spin_pkg::*;
#(
  parameter int unsigned BASE_DIV  = 2500,
  parameter int unsigned RAMP_STEP = 250,
  parameter int unsigned MAX_DIV   = 20000,
  parameter int unsigned MIN_TICKS = 16,
  parameter logic [2:0]  WIN_POS   = 3'd0,
  parameter int unsigned DIV_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               btn_i,
  input  logic               running_i,
  input  logic [2:0]         pos_i,
  output logic               tick_o,
  output logic               stop_o,
  output logic [1:0]         state_o,
  output logic               win_o,
  output logic [SCORE_W-1:0] score_o
);

  localparam logic [DIV_W-1:0] BASE_P = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] MAX_P  = DIV_W'(MAX_DIV);
  localparam logic [DIV_W:0]   RAMP_P = (DIV_W+1)'(RAMP_STEP);
  localparam int unsigned      CNT_W  = (MIN_TICKS < 1) ? 1 : $clog2(MIN_TICKS + 1);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_TICKS);

  state_e             state_q, state_d;
  logic               btn_q;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stop_q, stop_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               press;
  logic               tick;
  logic               div_clr;
  logic               div_en;
  logic               win_now;
  logic [DIV_W:0]     ramp_sum;
  logic [DIV_W-1:0]   ramp_sat;

  assign press   = btn_i & ~btn_q;
  assign win_now = (pos_i == WIN_POS);

  // Extra bit keeps the sum from wrapping before the saturation compare.
  assign ramp_sum = {1'b0, period_q} + RAMP_P;
  assign ramp_sat = (ramp_sum >= {1'b0, MAX_P}) ? MAX_P : ramp_sum[DIV_W-1:0];

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    win_d    = win_q;
    score_d  = score_q;
    div_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (press) begin
          state_d  = ST_SPIN;
          stop_d   = 1'b0;
          period_d = BASE_P;
          cnt_d    = '0;
          div_clr  = 1'b1;
        end
      end
      ST_SPIN: begin
        // Press is checked against the count before this cycle's tick lands.
        if (press && (cnt_q == MIN_P)) begin
          state_d = ST_BRAKE;
        end
        if (tick && (cnt_q != MIN_P)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BRAKE: begin
        if (tick) begin
          period_d = ramp_sat;
        end
        // Looking at the updated period raises stop on the same edge the
        // period saturates, and on the first BRAKE edge if BASE >= MAX.
        if (period_d >= MAX_P) begin
          stop_d = 1'b1;
        end
        if (stop_q && !running_i) begin
          state_d = ST_HALT;
          win_d   = win_now;
          if (win_now && (score_q != SCORE_MAX)) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enable follows the next state so no tick is scheduled into HALT.
  assign div_en = (state_d == ST_SPIN) || (state_d == ST_BRAKE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      btn_q    <= 1'b0;
      period_q <= BASE_P;
      cnt_q    <= '0;
      stop_q   <= 1'b1;
      win_q    <= 1'b0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_i;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      win_q    <= win_d;
      score_q  <= score_d;
    end
  end

  spin_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .en     (div_en),
    .clr    (div_clr),
    .period (period_q),
    .tick   (tick)
  );

  assign tick_o  = tick;
  assign stop_o  = stop_q;
  assign state_o = state_q;
  assign win_o   = win_q;
  assign score_o = score_q;

endmodule

// File: tb/tb_spin_ctrl.sv
// tb_spin_ctrl: self-checking bench for spin_ctrl with small divider settings.
// A schedule-based reference model (absolute tick times) is checked every
// cycle; a directed vector table and tick-time list pin down the round timing.
module tb_spin_ctrl;

  localparam int unsigned BASE = 4;
  localparam int unsigned RAMP = 2;
  localparam int unsigned MAXD = 10;
  localparam int unsigned MINT = 4;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       btn_i;
  logic       running_i;
  logic [2:0] pos_i;
  logic       tick_o;
  logic       stop_o;
  logic [1:0] state_o;
  logic       win_o;
  logic [7:0] score_o;

  always #5 clk = ~clk;

  spin_ctrl #(
    .BASE_DIV  (BASE),
    .RAMP_STEP (RAMP),
    .MAX_DIV   (MAXD),
    .MIN_TICKS (MINT),
    .WIN_POS   (3'd0),
    .DIV_W     (16)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .btn_i     (btn_i),
    .running_i (running_i),
    .pos_i     (pos_i),
    .tick_o    (tick_o),
    .stop_o    (stop_o),
    .state_o   (state_o),
    .win_o     (win_o),
    .score_o   (score_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: round state plus the absolute cycle of the next tick.
  int m_state, m_period, m_ticks, m_next, m_score;
  bit m_stop, m_win, m_btn_prev;

  // Wheel model: drops running a number of ticks after stop rises.
  int w_left;
  int w_ticks = 3;
  bit w_rand  = 1'b0;

  bit rec_on = 1'b0;
  int tick_q[$];

  typedef struct {
    logic       btn;
    logic [2:0] pos;
    int         n;
    logic [1:0] st;
    logic       stop;
    logic       win;
    logic [7:0] score;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_tick_exp();
    return ((m_state == 1) || (m_state == 2)) && (cyc == m_next);
  endfunction

  task automatic model_reset();
    m_state    = 0;
    m_period   = BASE;
    m_ticks    = 0;
    m_next     = -1;
    m_stop     = 1'b1;
    m_win      = 1'b0;
    m_score    = 0;
    m_btn_prev = 1'b0;
  endtask

  task automatic model_edge(input bit btn, input bit run, input int pos);
    bit press;
    bit tk;
    press      = btn && !m_btn_prev;
    tk         = m_tick_exp();
    m_btn_prev = btn;
    if (m_state == 0 || m_state == 3) begin
      if (press) begin
        m_state  = 1;
        m_stop   = 1'b0;
        m_period = BASE;
        m_ticks  = 0;
        m_next   = cyc + 1 + BASE;
      end
    end else if (m_state == 1) begin
      if (press && m_ticks == MINT) m_state = 2;
      if (tk) begin
        if (m_ticks < MINT) m_ticks++;
        m_next = cyc + BASE;
      end
    end else begin
      if (m_stop && !run) begin
        m_state = 3;
        m_win   = (pos == 0);
        if (m_win && m_score < 255) m_score++;
      end
      if (tk) begin
        m_period = (m_period + RAMP > MAXD) ? MAXD : m_period + RAMP;
        m_next   = cyc + m_period;
      end
      if (m_period >= MAXD) m_stop = 1'b1;
    end
  endtask

  task automatic wheel_update();
    if (!stop_o) begin
      running_i = 1'b1;
      w_left    = w_rand ? int'($urandom_range(1, 4)) : w_ticks;
    end else if (running_i && tick_o) begin
      w_left--;
      if (w_left <= 0) running_i = 1'b0;
    end
  endtask

  task automatic step(input bit btn, input logic [2:0] pos);
    btn_i = btn;
    pos_i = pos;
    model_edge(btn, running_i, int'(pos));
    @(posedge clk);
    #1;
    cyc++;
    chk("state", state_o, m_state);
    chk("stop", stop_o, m_stop);
    chk("tick", tick_o, m_tick_exp());
    chk("win", win_o, m_win);
    chk("score", score_o, m_score);
    if (rec_on && tick_o) tick_q.push_back(cyc);
    wheel_update();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int offs[10];
    bit seen;
    bit rb;

    offs = '{5, 9, 13, 17, 21, 27, 35, 45, 55, 65};

    //          btn   pos   n   st    stop  win   score
    vecs[0]  = '{1'b0, 3'd0, 100, 2'd0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 3'd0, 1,   2'd1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 3'd0, 9,   2'd1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 3'd0, 1,   2'd1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 3'd0, 7,   2'd1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 3'd0, 1,   2'd2, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 3'd0, 16,  2'd2, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 3'd0, 1,   2'd2, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 3'd0, 29,  2'd2, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 3'd0, 1,   2'd3, 1'b1, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 3'd0, 5,   2'd3, 1'b1, 1'b1, 8'd1};
    vecs[11] = '{1'b1, 3'd5, 1,   2'd1, 1'b0, 1'b1, 8'd1};
    vecs[12] = '{1'b0, 3'd5, 17,  2'd1, 1'b0, 1'b1, 8'd1};
    vecs[13] = '{1'b1, 3'd5, 1,   2'd2, 1'b0, 1'b1, 8'd1};
    vecs[14] = '{1'b0, 3'd5, 47,  2'd3, 1'b1, 1'b0, 8'd1};

    rst_n_i   = 1'b0;
    btn_i     = 1'b0;
    running_i = 1'b0;
    pos_i     = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_stop", stop_o, 1);
    chk("rst_tick", tick_o, 0);
    chk("rst_win", win_o, 0);
    chk("rst_score", score_o, 0);
    rst_n_i = 1'b1;
    cyc     = 0;
    model_reset();

    // Directed rounds from the vector table.
    p0 = 0;
    for (int r = 0; r < 15; r++) begin
      if (r == 1) begin
        p0     = cyc;
        rec_on = 1'b1;
      end
      for (int i = 0; i < vecs[r].n; i++) begin
        step((i == 0) ? vecs[r].btn : 1'b0, vecs[r].pos);
      end
      if (r == 10) rec_on = 1'b0;
      chk($sformatf("vec%0d_state", r), state_o, vecs[r].st);
      chk($sformatf("vec%0d_stop", r), stop_o, vecs[r].stop);
      chk($sformatf("vec%0d_win", r), win_o, vecs[r].win);
      chk($sformatf("vec%0d_score", r), score_o, vecs[r].score);
    end

    // Tick spacing of round one: 4,4,4,4 spinning, then 6,8,10,10,10 braking.
    chk("tick_count", tick_q.size(), 10);
    for (int i = 0; i < 10 && i < tick_q.size(); i++) begin
      chk($sformatf("tick_time%0d", i), tick_q[i] - p0, offs[i]);
    end

    // Asynchronous reset in a BRAKE cycle that carries a tick.
    step(1'b1, 3'd2);
    repeat (17) step(1'b0, 3'd2);
    step(1'b1, 3'd2);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(1'b0, 3'd2);
      if (tick_o && state_o == 2'd2) seen = 1'b1;
    end
    chk("brake_tick_seen", seen, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_stop", stop_o, 1);
    chk("async_rst_tick", tick_o, 0);
    chk("async_rst_win", win_o, 0);
    chk("async_rst_score", score_o, 0);
    btn_i     = 1'b0;
    running_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    model_reset();

    // Random button and wheel behaviour against the model.
    w_rand = 1'b1;
    rb     = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      step(rb, 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_ctrl.md
# spin_ctrl

Round sequencer for the LED-spinner wheel. Sits between the player button and the `wheel` instance. It generates the wheel's `tick_i` strobe with a programmable, decelerating period, issues the `stop_i` request at the end of braking, and waits for `running_o` to fall. It then latches the final position and keeps a win/score tally.

## Interface
- `BASE_DIV`, 2500: clocks per tick at full speed (50 µs at 50 MHz).
- `RAMP_STEP`, 250: clocks added to the tick period on every tick while braking.
- `MAX_DIV`, 20000: saturated tick period; reaching it triggers the stop request.
- `MIN_TICKS`, 16: ticks that must elapse in SPIN before a brake press is accepted.
- `WIN_POS`, 3'd0: wheel position that counts as a win.
- `DIV_W`, 16: width of the period and divider counters; must hold `MAX_DIV`.

Ports:
- `clk_i` in 1: system clock, 50 MHz.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `btn_i` in 1: player button, already synchronized and debounced, level, active-high.
- `running_i` in 1: from wheel `running_o`.
- `pos_i` in 3: from wheel `pos_o`.
- `tick_o` out 1: one-cycle strobe to wheel `tick_i`.
- `stop_o` out 1: to wheel `stop_i`.
- `state_o` out 2: current FSM state.
- `win_o` out 1: last round ended on `WIN_POS`.
- `score_o` out 8: number of won rounds, saturating.

## Operation
- Press = `btn_i & ~btn_q`, where `btn_q` is `btn_i` registered.
- Reset values:
  - state IDLE; `tick_o` 0; `stop_o` 1; `win_o` 0; `score_o` 0.
  - period = `BASE_DIV`; divider 0; tick count 0; `btn_q` 0.
- IDLE:
  - Divider held at 0, no ticks, `stop_o` 1.
  - Press -> SPIN: `stop_o` 0, period `BASE_DIV`, divider 0, tick count 0.
- SPIN:
  - Ticks at period `BASE_DIV`; tick count increments per tick, saturating at `MIN_TICKS`.
  - Press with tick count == `MIN_TICKS` -> BRAKE.
  - Earlier presses are ignored (not remembered).
- BRAKE:
  - On each tick: period = min(period + `RAMP_STEP`, `MAX_DIV`). The sum is computed in `DIV_W`+1 bits.
  - The new period applies from the next interval.
  - Once period == `MAX_DIV`, `stop_o` rises and stays 1. Ticking continues at `MAX_DIV`.
  - Presses are ignored.
  - `stop_o` == 1 and `running_i` == 0, sampled on a clock edge -> HALT.
- HALT:
  - No ticks, `stop_o` 1.
  - On entry: `win_o` = (`pos_i` == `WIN_POS`); `score_o` += `win_o`, saturating at 255.
  - Press -> SPIN, using the same loading as from IDLE. `win_o` holds until the next HALT entry.
- `state_o` encoding: IDLE 0, SPIN 1, BRAKE 2, HALT 3.

## Timing
- Divider:
  - Counts 0..period−1.
  - `tick_o` is a registered 1 in the cycle after the divider equals period−1; the divider returns to 0 at the same time.
  - First tick after entering SPIN: `BASE_DIV`+1 cycles after the cycle in which the press was sampled.
- Press latency: `state_o` changes on the first clock edge at which `btn_i`=1 and `btn_q`=0.
- Saturation:
  - The tick that makes period reach `MAX_DIV` sets `stop_o` on the following edge.
  - If `BASE_DIV` ≥ `MAX_DIV`, `stop_o` rises on the first edge in BRAKE.
- Same-cycle events: `running_i` falling in the same cycle as a tick -> HALT wins, and the tick is still emitted this cycle only.
- HALT capture: `pos_i` is sampled on the same edge that enters HALT.
- Reset asserted mid-round: all registers go to reset values immediately; the wheel sees `stop_o`=1 and no ticks.

## Structure
- `spin_pkg`:
  - State encodings (`ST_IDLE`, `ST_SPIN`, `ST_BRAKE`, `ST_HALT`).
  - `SCORE_W`=8.
- Sub-module `spin_tick_gen`: programmable divider.
  - Inputs: `en`, `period[DIV_W-1:0]`, `clr`.
  - Output: registered `tick`.
- Top level: FSM, press detect, period ramp, score/win logic.

## Test plan
All scenarios use `BASE_DIV`=4, `RAMP_STEP`=2, `MAX_DIV`=10, `MIN_TICKS`=4, `WIN_POS`=0, with a wheel model that drops `running_i` 3 ticks after `stop_o`.
- Reset, then idle for 100 cycles -> `tick_o` never high, `stop_o`=1, `state_o`=0, `score_o`=0.
- Press in IDLE -> `state_o`=1 next edge, `stop_o`=0, ticks spaced exactly 4 cycles apart.
- Press after 2 SPIN ticks -> ignored, state stays 1. Press after 4 ticks -> `state_o`=2.
- Braking -> tick intervals 6, 8, 10, 10…
  - `stop_o` rises one cycle after the third braking tick.
  - HALT entered when `running_i` falls.
- HALT with `pos_i`=0 -> `win_o`=1, `score_o`=1. Next round with `pos_i`=5 -> `win_o`=0, `score_o`=1.
- Assert `rst_n_i` low mid-BRAKE -> outputs return to reset values within the same cycle, with no clock edge required.
